mmio_uart_tx: RTL
=================

# mmio_uart_tx

Memory-mapped UART transmitter that sits on the RISC16 core's data-memory bus as a responder, alongside `mem_data`. It decodes a 16-word window at the top of the address space. Byte writes from the core go into a small FIFO, and the block serializes them as 8N1 frames on `o_tx`. Reads are combinational so that single-cycle load instructions complete in one clock.

## Interface
- `p_BASE_ADDR`, default 16'hFF00: first word address of the window. Must be 16-aligned.
- `p_CLK_DIV`, default 868: clock cycles per serial bit. Must be ≥ 2.
- `p_FIFO_ADDR_LEN`, default 3: FIFO depth = 1 << `p_FIFO_ADDR_LEN`. Depth 8 by default.
- `i_clk` input 1: the single clock. All state updates on the rising edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_mem_addr` input 16: core data address (`o_mem_addr`).
- `i_mem_wr_data` input 16: core write data.
- `i_mem_wr_en` input 1: core write strobe.
- `o_mem_rd_data` output 16: read data. Combinational. Equals 0 when `o_sel` = 0.
- `o_sel` output 1: combinational. High when `i_mem_addr[15:4]` == `p_BASE_ADDR[15:4]`. The integrator uses it to mux read data and to gate `mem_data` writes.
- `o_tx` output 1: serial line. Registered. Idle high.

## Operation
Register map (word offsets from `p_BASE_ADDR`):
- +0 TXDATA
  - Write: push `i_mem_wr_data[7:0]`. Bits [15:8] are ignored.
  - Read: returns 0.
- +1 STATUS (read-only; writes ignored)
  - [15:8] = 0
  - [7] full
  - [6] empty
  - [5] busy (serializer not IDLE)
  - [4] overflow (sticky)
  - [3:0] FIFO count, 0..depth
- +2 CTRL
  - Bit0: enable. Read/write.
  - Bit1: write 1 to clear overflow. Self-clearing; reads 0.
  - Other bits: read 0.
- +3..+15: read 0; writes ignored.

Writes and FIFO rules:
- A write is accepted only when `i_mem_wr_en` and `o_sel` are both high.
- Push when full: the byte is dropped and overflow is set. Fullness is sampled before the edge, so a same-cycle pop does not make room.
- Push and pop in the same cycle when not full: both occur, and count is unchanged.
- Overflow set and clear in the same cycle: set wins.
- FIFO pointers wrap modulo depth. Count is a separate 4-bit counter, which supports depths up to 8. Depth > 8 is unsupported.

Serializer FSM (states IDLE, START, DATA, STOP):
- IDLE: `o_tx` = 1. If enable = 1 and FIFO is not empty, pop the head into the shift register and go to START.
- START: `o_tx` = 0 for `p_CLK_DIV` cycles, then go to DATA with bit index 0.
- DATA: `o_tx` = shift[0], LSB first, `p_CLK_DIV` cycles per bit. Shift right after each bit. After bit 7, go to STOP.
- STOP: `o_tx` = 1 for `p_CLK_DIV` cycles. At the end of STOP, if enable = 1 and FIFO is not empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Clearing enable never aborts a frame in flight. It only blocks the next pop.
- Baud counter: counts 0..`p_CLK_DIV`-1, is cleared on every state or bit transition, and its width is `$clog2(p_CLK_DIV)`.

## Timing
- Reset values:
  - `o_tx` = 1
  - FSM = IDLE
  - FIFO empty (count 0), overflow = 0, enable = 1
  - `o_mem_rd_data` and `o_sel` follow the address combinationally.
- Reset mid-frame: at the next edge the FSM goes to IDLE, `o_tx` = 1, and FIFO contents are discarded. A write in the same cycle as reset is ignored.
- Write latency: a TXDATA write at edge N gives count = 1 after edge N. If the serializer is idle and enabled, the pop occurs at edge N+1 and `o_tx` = 0 from edge N+1.
- Frame length: exactly 10·`p_CLK_DIV` cycles.
- Back-to-back frames: stop bit of one frame is followed immediately by the next start bit.
- STATUS reads reflect the register state before the current edge.

## Test plan
All scenarios use `p_CLK_DIV` = 4 and base 16'hFF00.
- **Single byte:** reset, write 16'h00A5 to FF00.
  - `o_tx` from edge N+1: 0, then 1,0,1,0,0,1,0,1, then 1, each level held 4 cycles, 40 cycles total.
  - STATUS reads 16'h0040 afterwards.
- **Overflow:** write CTRL = 0, then 9 TXDATA writes.
  - STATUS = 16'h0098 and `o_tx` stays 1.
  - Write CTRL = 16'h0002: STATUS = 16'h0088 and enable stays 0.
- **Back-to-back:** with enable = 0, queue 16'h0055 and 16'h00FF, then write CTRL = 1.
  - 80 contiguous frame cycles with no idle gap.
  - busy deasserts and empty = 1 at the end.
- **Reset mid-frame:** queue 3 bytes, assert `i_rst` at cycle 15 of frame 1.
  - Next edge: `o_tx` = 1, STATUS = 16'h0040, no further frames.
- **Decode:**
  - Read FF05: `o_sel` = 1, data 0.
  - Read 03FF: `o_sel` = 0, data 0.
  - Write 16'h0012 to 03FF: FIFO count unchanged.
  - Read FF02 after reset: 16'h0001.
- **Push and pop same cycle:** with one byte queued and the serializer in STOP, write TXDATA on the final STOP cycle.
  - Count stays 1 and the next frame starts immediately.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO.
// Responds to a 16-word window on the core data bus.
module mmio_uart_tx #(
    parameter logic [15:0] p_BASE_ADDR     = 16'hFF00,
    parameter int          p_CLK_DIV       = 868,
    parameter int          p_FIFO_ADDR_LEN = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_mem_addr,
    input  logic [15:0] i_mem_wr_data,
    input  logic        i_mem_wr_en,
    output logic [15:0] o_mem_rd_data,
    output logic        o_sel,
    output logic        o_tx
);

    localparam int DEPTH = 1 << p_FIFO_ADDR_LEN;
    localparam int AW    = p_FIFO_ADDR_LEN;
    localparam int CW    = $clog2(p_CLK_DIV);

    localparam logic [3:0]    FULL_CNT = 4'(DEPTH);
    localparam logic [CW-1:0] LAST     = CW'(p_CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tx;
    logic          tx_next;
    logic          pop;
    logic          baud_end;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [3:0]    count;
    logic          ovf;
    logic          en;

    logic [3:0]    offset;
    logic          wr;
    logic          wr_tx;
    logic          wr_ctrl;
    logic          full;
    logic          empty;
    logic          push;
    logic          ovf_set;
    logic          ovf_clr;
    logic          unused_hi;

    assign offset    = i_mem_addr[3:0];
    assign o_sel     = (i_mem_addr[15:4] == p_BASE_ADDR[15:4]);
    assign wr        = i_mem_wr_en & o_sel;
    assign wr_tx     = wr && (offset == 4'd0);
    assign wr_ctrl   = wr && (offset == 4'd2);
    assign full      = (count == FULL_CNT);
    assign empty     = (count == 4'd0);
    assign push      = wr_tx && !full;
    assign ovf_set   = wr_tx && full;
    assign ovf_clr   = wr_ctrl && i_mem_wr_data[1];
    assign baud_end  = (baud == LAST);
    assign o_tx      = tx;
    assign unused_hi = ^i_mem_wr_data[15:8];

    // Combinational register read mux; zero outside the window.
    always_comb begin
        o_mem_rd_data = '0;
        if (o_sel) begin
            unique case (offset)
                4'd1:    o_mem_rd_data = {8'h00, full, empty,
                                          (state != IDLE), ovf, count};
                4'd2:    o_mem_rd_data = {15'h0000, en};
                default: o_mem_rd_data = '0;
            endcase
        end
    end

    // FIFO storage; contents need no reset.
    always_ff @(posedge i_clk) begin
        if (push && !i_rst) begin
            mem[wr_ptr] <= i_mem_wr_data[7:0];
        end
    end

    // FIFO pointers, count, enable and sticky overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            en     <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
            if (wr_ctrl) en <= i_mem_wr_data[0];
        end
    end

    // Serializer state, baud counter, shift register and line output.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state <= state_next;
            tx    <= tx_next;
            if (state_next != state || (state == DATA && baud_end))
                baud <= '0;
            else if (state != IDLE)
                baud <= baud + 1'b1;
            if (state != DATA)
                bit_idx <= '0;
            else if (baud_end)
                bit_idx <= bit_idx + 3'd1;
            if (pop)
                shift <= mem[rd_ptr];
            else if (state == DATA && baud_end)
                shift <= {1'b0, shift[7:1]};
        end
    end

    // Next state, pop request and the line level for the next cycle.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx_next    = 1'b1;
        unique case (state)
            IDLE: begin
                if (en && !empty) begin
                    pop        = 1'b1;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (baud_end) begin
                    state_next = DATA;
                    tx_next    = shift[0];
                end
            end
            DATA: begin
                tx_next = shift[0];
                if (baud_end) begin
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        tx_next = shift[1];
                    end
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (baud_end) begin
                    if (en && !empty) begin
                        pop        = 1'b1;
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
